// File: rtl/serial_to_parallel_array.sv
// serial_to_parallel_array: deserializes a signed sample stream into LANES-wide frames
// with valid/ready on both sides, double buffering, selectable fill order and early flush.
module serial_to_parallel_array #(
  parameter int WIDTH = 16,
  parameter int LANES = 8,
  parameter bit MSB_FIRST = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic signed [WIDTH-1:0]          serial_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             flush,
  output logic signed [WIDTH-1:0]          parallel_out [0:LANES-1],
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(LANES+1)-1:0]       out_count
);
  localparam int IW = $clog2(LANES);
  localparam int CW = $clog2(LANES+1);
  logic signed [WIDTH-1:0] fill  [0:LANES-1];
  logic signed [WIDTH-1:0] frame [0:LANES-1];
  logic [IW-1:0] idx, lane;
  logic [CW-1:0] pend_cnt, cnt;
  logic accept, last, complete, slot_free, pending;
  // in_ready is itself the registered inverse of the pending flag
  assign pending   = !in_ready;
  assign accept    = in_valid && in_ready;
  assign last      = idx == IW'(LANES-1);
  assign complete  = accept ? (last || flush) : (flush && in_ready && idx != '0);
  assign cnt       = (accept && last) ? CW'(LANES) : CW'(idx) + CW'(accept);
  assign slot_free = !out_valid || out_ready;
  assign lane      = MSB_FIRST ? IW'(LANES-1) - idx : idx;
  always_comb begin
    frame = fill;
    if (accept) frame[lane] = serial_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill         <= '{default: '0};
      parallel_out <= '{default: '0};
      idx          <= '0;
      pend_cnt     <= '0;
      out_count    <= '0;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
    end else if (pending && slot_free) begin
      parallel_out <= fill;
      out_count    <= pend_cnt;
      out_valid    <= 1'b1;
      fill         <= '{default: '0};
      idx          <= '0;
      in_ready     <= 1'b1;
    end else if (complete && slot_free) begin
      parallel_out <= frame;
      out_count    <= cnt;
      out_valid    <= 1'b1;
      fill         <= '{default: '0};
      idx          <= '0;
    end else begin
      if (complete) begin
        fill     <= frame;
        pend_cnt <= cnt;
        in_ready <= 1'b0;
      end else if (accept) begin
        fill <= frame;
        idx  <= idx + IW'(1);
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_to_parallel_array.sv
// tb_serial_to_parallel_array: directed and random checks against a frame-queue model.
module tb_serial_to_parallel_array;
  logic clk = 0, rst_n = 0;
  logic signed [15:0] serial_in = '0;
  logic in_valid = 0, flush = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic signed [15:0] parallel_out [0:7];
  logic [3:0] out_count;
  logic signed [11:0] si2 = '0;
  logic iv2 = 0, fl2 = 0, or2 = 1;
  logic ir2, ov2;
  logic signed [11:0] po2 [0:3];
  logic [2:0] oc2;
  int checks = 0, errors = 0;

  typedef struct packed { logic [3:0] cnt; logic [7:0][15:0] d; } exp_t;
  exp_t exp_q[$];
  logic [15:0] cur[$];

  always #5 clk = ~clk;

  serial_to_parallel_array dut (.clk(clk), .rst_n(rst_n), .serial_in(serial_in), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .parallel_out(parallel_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count));

  serial_to_parallel_array #(.WIDTH(12), .LANES(4), .MSB_FIRST(1)) dut2 (.clk(clk), .rst_n(rst_n),
    .serial_in(si2), .in_valid(iv2), .in_ready(ir2), .flush(fl2), .parallel_out(po2),
    .out_valid(ov2), .out_ready(or2), .out_count(oc2));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: at the falling edge score any consumed frame and predict what the next edge
  // accepts or closes; return 1ns after the rising edge for the next drive.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chk("frame_queued", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("frame_count", out_count, e.cnt);
        for (int k = 0; k < 8; k++) chk($sformatf("frame_lane%0d", k), parallel_out[k], $signed(e.d[k]));
      end
    end
    if (in_valid && in_ready) cur.push_back(serial_in);
    if ((in_valid && in_ready && cur.size() == 8) || (in_ready && flush && cur.size() != 0)) begin
      e = '0;
      e.cnt = 4'(cur.size());
      for (int k = 0; k < cur.size(); k++) e.d[k] = cur[k];
      exp_q.push_back(e);
      cur.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic signed [15:0] v);
    in_valid = 1; serial_in = v;
    cycle();
    in_valid = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    for (int k = 0; k < 8; k++) chk("rst_lane", parallel_out[k], 0);
    rst_n = 1;
    cycle();
    // back-to-back streaming, out_ready high
    for (int i = 1; i <= 16; i++) begin
      send(-i);
      chk("t1_in_ready", in_ready, 1);
      chk("t1_out_valid", out_valid, (i % 8 == 0) ? 1 : 0);
      if (i == 8) begin
        chk("t1_lane0", parallel_out[0], -1);
        chk("t1_lane7", parallel_out[7], -8);
        chk("t1_count", out_count, 8);
      end
    end
    cycle();
    chk("t1_drained", out_valid, 0);
    // backpressure: one frame held, one pending, 17th stalls
    out_ready = 0;
    for (int i = 1; i <= 16; i++) begin
      send(100 + i);
      chk("t3_in_ready", in_ready, (i < 16) ? 1 : 0);
    end
    in_valid = 1; serial_in = 117;
    repeat (2) cycle();
    chk("t3_stall_ready", in_ready, 0);
    chk("t3_hold_lane0", parallel_out[0], 101);
    chk("t3_hold_count", out_count, 8);
    out_ready = 1;
    cycle();
    out_ready = 0;
    chk("t3_swap_valid", out_valid, 1);
    chk("t3_swap_ready", in_ready, 1);
    chk("t3_swap_lane0", parallel_out[0], 109);
    chk("t3_swap_lane7", parallel_out[7], 116);
    cycle();
    in_valid = 0;
    out_ready = 1;
    cycle();
    flush = 1; cycle(); flush = 0;
    chk("t3_17_count", out_count, 1);
    chk("t3_17_lane0", parallel_out[0], 117);
    chk("t3_17_lane1", parallel_out[1], 0);
    // flush cases
    send(10); send(20); send(30);
    flush = 1; cycle(); flush = 0;
    chk("t4_count", out_count, 3);
    chk("t4_lane2", parallel_out[2], 30);
    chk("t4_lane3", parallel_out[3], 0);
    chk("t4_lane7", parallel_out[7], 0);
    flush = 1; cycle(); flush = 0;
    chk("t4_empty_flush", out_valid, 0);
    cycle();
    chk("t4_empty_flush2", out_valid, 0);
    send(1); send(2); send(3);
    flush = 1; send(4); flush = 0;
    chk("t4_flush_acc_valid", out_valid, 1);
    chk("t4_flush_acc_count", out_count, 4);
    chk("t4_flush_acc_lane3", parallel_out[3], 4);
    chk("t4_flush_acc_lane4", parallel_out[4], 0);
    // reset mid-frame with a frame held in the output register
    out_ready = 0;
    for (int i = 0; i < 5; i++) send(50 + i);
    chk("t5_pre_valid", out_valid, 1);
    rst_n = 0;
    #2;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_count", out_count, 0);
    for (int k = 0; k < 8; k++) chk("t5_lane", parallel_out[k], 0);
    cur.delete(); exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    for (int i = 1; i <= 8; i++) send(200 + i);
    chk("t5_frame_lane0", parallel_out[0], 201);
    chk("t5_frame_lane7", parallel_out[7], 208);
    chk("t5_frame_count", out_count, 8);
    cycle();
    // narrow, reversed-order instance
    iv2 = 1;
    foreach (po2[k]) begin
      si2 = (k == 0) ? -12'sd2048 : (k == 1) ? 12'sd2047 : (k == 2) ? -12'sd1 : 12'sd0;
      @(posedge clk); #1;
    end
    iv2 = 0;
    chk("t6_valid", ov2, 1);
    chk("t6_count", oc2, 4);
    chk("t6_lane3", po2[3], -2048);
    chk("t6_lane2", po2[2], 2047);
    chk("t6_lane1", po2[1], -1);
    chk("t6_lane0", po2[0], 0);
    iv2 = 1; si2 = 12'sd5; @(posedge clk); #1;
    si2 = -12'sd6; fl2 = 1; @(posedge clk); #1;
    iv2 = 0; fl2 = 0;
    chk("t6f_count", oc2, 2);
    chk("t6f_lane3", po2[3], 5);
    chk("t6f_lane2", po2[2], -6);
    chk("t6f_lane1", po2[1], 0);
    chk("t6f_lane0", po2[0], 0);
    // random traffic scored against the frame queue
    for (int n = 0; n < 600; n++) begin
      in_valid = $urandom_range(3) != 0;
      serial_in = 16'($urandom);
      flush = $urandom_range(15) == 0;
      out_ready = $urandom_range(1) != 0;
      cycle();
    end
    in_valid = 0; out_ready = 1; flush = 1;
    cycle();
    flush = 0;
    repeat (4) cycle();
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel_array.md
# serial_to_parallel_array

Parametrised deserializer that collects a stream of signed samples into a `LANES`-wide unpacked array frame. It is the front end of the array datapath: it feeds array consumers that take `parallel_out [0:LANES-1]`. Compared with the fixed 16-bit × 8 block, it adds:

- generic width and lane count;
- valid/ready handshakes on both sides;
- double buffering for full-rate streaming;
- selectable lane fill order;
- early frame termination (flush) with a lane count.

## Interface

Parameters:

- `WIDTH`, 16: sample width in bits, signed; must be ≥ 2.
- `LANES`, 8: samples per frame; must be ≥ 2.
- `MSB_FIRST`, 0: 0 puts sample k of a frame in lane k; 1 puts it in lane `LANES-1-k`.

Ports:

- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous assert, active-low reset.
- `serial_in` input signed [WIDTH-1:0]: input sample.
- `in_valid` input 1: `serial_in` is valid.
- `in_ready` output 1: block can accept a sample; registered.
- `flush` input 1: close the current frame early.
- `parallel_out` output signed [WIDTH-1:0] [0:LANES-1]: frame array; registered.
- `out_valid` output 1: `parallel_out` and `out_count` hold a frame.
- `out_ready` input 1: downstream consumes the frame.
- `out_count` output [$clog2(LANES+1)-1:0]: number of filled lanes in the frame (1..LANES).

## Operation

- Storage:
  - fill buffer of `LANES` entries, with write index `idx` (0..LANES-1) and flag `pending`;
  - output register, with flag `out_valid`.
- `in_ready = !pending`. A sample is accepted when `in_valid && in_ready`.
- Accept with no frame completion:
  - the sample is written to lane `idx` (or lane `LANES-1-idx` when `MSB_FIRST=1`);
  - `idx` increments.
- A frame completes on:
  - an accept when `idx == LANES-1`, giving count `LANES`; or
  - `flush && in_ready` with an accept, giving count `idx+1`; or
  - `flush && in_ready` with no accept and `idx > 0`, giving count `idx`.
- `flush` with an empty buffer (`idx == 0`) and no accept is ignored. `flush` while `pending=1` is ignored.
- Unfilled lanes of a flushed frame are zero in `parallel_out`.
- Transfer condition: the output slot is free when `!out_valid || out_ready`.
- On a completing edge with the slot free:
  - the completed frame, including the sample accepted that edge, loads directly into the output register;
  - `out_valid` is set to 1, the fill buffer is cleared, and `idx` is set to 0.
- On a completing edge with the slot busy:
  - the frame stays in the fill buffer and `pending` is set to 1;
  - at the first edge where the slot is free, the frame transfers, `pending` clears and `idx` is set to 0.
- Output handshake:
  - `out_valid && out_ready` with no transfer at that edge sets `out_valid` to 0;
  - `parallel_out` and `out_count` hold their values while `out_valid=1 && out_ready=0`.
- Samples are stored bit-exact, with no sign extension or saturation; the signed type is carried to the outputs.
- Reset (`rst_n=0`, at any time, including mid-frame or with `pending=1`):
  - `in_ready=1`, `out_valid=0`, `out_count=0`;
  - all `parallel_out` lanes are 0;
  - `idx=0`, `pending=0`, fill buffer cleared.
  - The partial frame is discarded.

## Timing

- Latency: the last sample accepted at edge t gives `out_valid=1` from edge t, visible in cycle t+1, provided the slot is free.
- Throughput: with `out_ready` held at 1, one sample is accepted per cycle indefinitely, with no `in_ready` drop. Frames appear every `LANES` cycles.
- Backpressure path:
  - `in_ready` falls in the cycle after a frame completes into a busy slot;
  - it rises in the cycle after the pending frame transfers;
  - there is no combinational path from `out_ready` to `in_ready`.
- Simultaneous events:
  - a pending transfer and the consumption of the old frame on the same edge leave `out_valid=1` with the new frame;
  - `flush` and an accept on the same edge: the sample is included, then the frame closes.
- All outputs are flop-driven.

## Test plan

1. Default parameters, `out_ready=1`, 16 back-to-back samples -1..-16:
   - first frame has `parallel_out[0]=-1` … `[7]=-8`, `out_count=8`, `out_valid` one cycle after the 8th accept;
   - second frame has -9..-16;
   - `in_ready` stays 1 throughout.
2. `MSB_FIRST=1`, samples -1..-8 → `parallel_out[7]=-1`, `parallel_out[0]=-8`.
3. `out_ready=0`, 17 samples offered:
   - frame 1 is held in the output register;
   - frame 2 goes to pending, and `in_ready=0` from the cycle after the 16th accept, so the 17th sample is stalled;
   - pulse `out_ready` for one cycle → `out_valid` stays 1 with frame 2, and `in_ready=1` the next cycle;
   - the 17th sample then lands in lane 0.
4. Flush cases:
   - samples 10, 20, 30 then `flush` → `out_count=3`, lanes 0..2 = 10/20/30, lanes 3..7 = 0;
   - `flush` on an empty buffer → no frame produced;
   - `flush` together with the 4th accept of 1..4 → `out_count=4`.
5. Assert `rst_n` low for one cycle after 5 accepted samples while `out_valid=1` → all outputs and the buffer clear; the next 8 samples form a complete frame starting at lane 0.
6. `WIDTH=12`, `LANES=4`, samples -2048, 2047, -1, 0 → values preserved exactly, `out_count=4`.
